uncache_wbuf: RTL and testbench
===============================

// Module: uncache_wbuf
// PURPOSE
//  Posted-write buffer between the CPU uncache port and the memory arbiter's uncache port.
//  Accepts uncached/MMIO stores in 1 cycle and drains them to the arbiter in FIFO order.
//  Uncached loads are held until every earlier store has been written out.
//  This keeps strict MMIO ordering while hiding AXI write latency from the pipeline.
// PARAMETERS
//  DEPTH   4   write entries; power of two, >=2
//  ADDR_W  32  uncache address width
//  DATA_W  64  data width; mask width is DATA_W/8
// PORTS
//  clk          in   1       single clock, all logic rising-edge
//  rst          in   1       asynchronous, active-low reset
//  cpu_re_i     in   1       uncached load request, level, held until cpu_refresh_o
//  cpu_we_i     in   1       uncached store request, level, held until cpu_refresh_o
//  cpu_mask_i   in   DATA_W/8 byte strobes
//  cpu_addr_i   in   ADDR_W  address
//  cpu_size_i   in   2       access size, log2 bytes
//  cpu_wdata_i  in   DATA_W  store data
//  cpu_rdata_o  out  DATA_W  load data, valid while cpu_refresh_o=1
//  cpu_refresh_o out 1       1-cycle completion pulse
//  arb_re_o     out  1       load to arbiter, held until arb_refresh_i
//  arb_we_o     out  1       store to arbiter, held until arb_refresh_i
//  arb_mask_o / arb_addr_o / arb_size_o / arb_wdata_o  out  same widths as cpu_*_i
//  arb_rdata_i  in   DATA_W  arbiter load data, valid with arb_refresh_i
//  arb_refresh_i in  1       1-cycle arbiter completion pulse
// BEHAVIOUR
//  Reset (rst=0): all outputs 0, FIFO empty, FSM IDLE, ack register 0.
//   A reset mid-transfer abandons the transfer and drops buffered stores.
//  CPU acknowledge: cpu_refresh_o is a registered 1-cycle pulse.
//   While it is high, no new CPU request is sampled; this prevents double-enqueue.
//  Store accept: if cpu_we_i=1, count<DEPTH, and ack=0, enqueue {addr,size,mask,wdata} at the edge.
//   cpu_refresh_o=1 on the next cycle (latency 1).
//   When the FIFO is full, the CPU stalls; there is no same-cycle pop-to-push bypass.
//   Enqueue is evaluated against count before any pop in that cycle.
//  Simultaneous push and pop (count<DEPTH): both happen; count is unchanged.
//  Pointers: PTR_W=$clog2(DEPTH) bits, wrap DEPTH-1 -> 0.
//   count is PTR_W+1 bits; full = (count==DEPTH), empty = (count==0).
//  FSM IDLE/WR/RD:
//   IDLE->WR  when !empty. Drive arb_we_o=1 with the head entry, all arb_* fields stable.
//   WR->IDLE  on arb_refresh_i. Pop the head. One idle bubble is required before the next drain.
//   IDLE->RD  when cpu_re_i=1, empty, ack=0, and no store is being accepted this cycle.
//             Latch addr/size/mask; drive arb_re_o=1.
//   RD->IDLE  on arb_refresh_i. Register arb_rdata_i into cpu_rdata_o; pulse cpu_refresh_o next cycle.
//   Load latency = arbiter latency + 1.
//  Store ordering: a load never passes a buffered store. There is no store-to-load forwarding, because these are MMIO addresses.
//  cpu_we_i and cpu_re_i both high is illegal. The store wins, and a simulation assertion fires.
//  arb_refresh_i while in IDLE is ignored (assertion).
//  cpu_rdata_o holds its last value and is 0 after reset.
// CONFIGURATION
//  UNCACHE_WBUF_PERF_EN defined:
//   Adds outputs perf_stall_o[31:0], counting cycles with cpu_we_i=1 and full.
//   Adds outputs perf_wr_o[31:0], counting drained stores.
//   Both are saturating, reset to 0.
//  UNCACHE_WBUF_PERF_EN undefined: these ports and counters do not exist; behaviour is otherwise identical.
// STRUCTURE
//  Shared defines.v holds:
//   FSM encodings WBUF_IDLE=2'd0, WBUF_WR=2'd1, WBUF_RD=2'd2.
//   Entry width macro WBUF_ENTRY_W = ADDR_W+2+DATA_W/8+DATA_W.
//  Sub-module wbuf_fifo (DEPTH x WBUF_ENTRY_W): register array, wr/rd pointers, count, full/empty.
//   It has its own clk/rst ports.
//  The FSM, ack register and read latch live in uncache_wbuf.
// TESTING
//  1. Store addr 0xa0000000, wdata 0x41, mask 0x01, arbiter ack after 5 cycles.
//     -> cpu_refresh_o 1 cycle after request; arb_we_o with the same fields one cycle later; count returns to 0.
//  2. Five back-to-back stores with arbiter stalled (DEPTH=4).
//     -> 4 acks; 5th stalls with cpu_refresh_o=0 until the first arb_refresh_i, then is accepted.
//  3. Store to 0x10000000, then load from 0x10000000.
//     -> arb_re_o asserts only after the store's arb_refresh_i.
//     -> cpu_rdata_o = arb_rdata_i (e.g. 0xdeadbeef); cpu_refresh_o one cycle after arb_refresh_i.
//  4. Pulse rst low while in WR with 3 entries.
//     -> all outputs 0 immediately; after release, empty and no arb_we_o.
//  5. Push and pop in the same cycle at count=2.
//     -> count stays 2; FIFO order is preserved across the pointer wrap (16 stores, data 0..15 out in order).
//  6. UNCACHE_WBUF_PERF_EN: test 2 -> perf_stall_o = stalled cycles, perf_wr_o = 5.

Source files
------------

// File: rtl/uncache_wbuf_pkg.sv
// uncache_wbuf_pkg: FSM encoding and entry-width helper shared by the uncache write buffer
package uncache_wbuf_pkg;

    typedef enum logic [1:0] {
        WBUF_IDLE = 2'd0,
        WBUF_WR   = 2'd1,
        WBUF_RD   = 2'd2
    } wbuf_state_e;

    // One buffered store is {addr, size, mask, wdata}
    function automatic int wbuf_entry_w(input int addr_w, input int data_w);
        return addr_w + 2 + data_w / 8 + data_w;
    endfunction

endpackage

// File: rtl/uncache_wbuf_fifo.sv
// uncache_wbuf_fifo: DEPTH-entry register FIFO with count/full/empty, asynchronous active-low reset
module uncache_wbuf_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 106
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full_o   = count_q == (PTR_W + 1)'(DEPTH);
    assign empty_o  = count_q == '0;
    assign do_push  = push_i && !full_o;
    assign do_pop   = pop_i && !empty_o;
    assign wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    assign rd_ptr_d = do_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    assign count_d  = count_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
    assign rdata_o  = mem_q[rd_ptr_q];

    // Storage needs no reset: a dropped entry is unreachable once the pointers clear
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uncache_wbuf.sv
// uncache_wbuf: posted-write buffer for uncached/MMIO traffic; loads wait for all earlier stores.
// Optional UNCACHE_WBUF_PERF_EN adds saturating stall/drain counters. Reset rst is async active-low.
module uncache_wbuf
    import uncache_wbuf_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_re_i,
    input  logic                cpu_we_i,
    input  logic [DATA_W/8-1:0] cpu_mask_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [1:0]          cpu_size_i,
    input  logic [DATA_W-1:0]   cpu_wdata_i,
    output logic [DATA_W-1:0]   cpu_rdata_o,
    output logic                cpu_refresh_o,
    output logic                arb_re_o,
    output logic                arb_we_o,
    output logic [DATA_W/8-1:0] arb_mask_o,
    output logic [ADDR_W-1:0]   arb_addr_o,
    output logic [1:0]          arb_size_o,
    output logic [DATA_W-1:0]   arb_wdata_o,
    input  logic [DATA_W-1:0]   arb_rdata_i,
    input  logic                arb_refresh_i
`ifdef UNCACHE_WBUF_PERF_EN
    ,
    output logic [31:0]         perf_stall_o,
    output logic [31:0]         perf_wr_o
`endif
);
    localparam int MW = DATA_W / 8;
    localparam int EW = wbuf_entry_w(ADDR_W, DATA_W);

    wbuf_state_e       state_q, state_d;
    logic              ack_q, ack_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [1:0]        rd_size_q, rd_size_d;
    logic [MW-1:0]     rd_mask_q, rd_mask_d;
    logic [EW-1:0]     head;
    logic [ADDR_W-1:0] h_addr;
    logic [1:0]        h_size;
    logic [MW-1:0]     h_mask;
    logic [DATA_W-1:0] h_wdata;
    logic              full, empty, push, pop, rd_start;

    // No sampling while the ack pulse is high, so a held request is never enqueued twice
    assign push     = cpu_we_i && !full && !ack_q;
    assign pop      = state_q == WBUF_WR && arb_refresh_i;
    assign rd_start = empty && cpu_re_i && !cpu_we_i && !ack_q;

    uncache_wbuf_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({cpu_addr_i, cpu_size_i, cpu_mask_i, cpu_wdata_i}),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign {h_addr, h_size, h_mask, h_wdata} = head;

    assign arb_we_o      = state_q == WBUF_WR;
    assign arb_re_o      = state_q == WBUF_RD;
    assign arb_addr_o    = arb_we_o ? h_addr : arb_re_o ? rd_addr_q : '0;
    assign arb_size_o    = arb_we_o ? h_size : arb_re_o ? rd_size_q : '0;
    assign arb_mask_o    = arb_we_o ? h_mask : arb_re_o ? rd_mask_q : '0;
    assign arb_wdata_o   = arb_we_o ? h_wdata : '0;
    assign cpu_refresh_o = ack_q;
    assign cpu_rdata_o   = rdata_q;

    // Next state: drain stores first; a load only starts once the buffer is empty
    always_comb begin
        state_d   = state_q;
        ack_d     = push;
        rdata_d   = rdata_q;
        rd_addr_d = rd_addr_q;
        rd_size_d = rd_size_q;
        rd_mask_d = rd_mask_q;
        case (state_q)
            WBUF_IDLE: begin
                if (!empty) begin
                    state_d = WBUF_WR;
                end else if (rd_start) begin
                    state_d   = WBUF_RD;
                    rd_addr_d = cpu_addr_i;
                    rd_size_d = cpu_size_i;
                    rd_mask_d = cpu_mask_i;
                end
            end
            WBUF_WR: begin
                if (arb_refresh_i) state_d = WBUF_IDLE;
            end
            WBUF_RD: begin
                if (arb_refresh_i) begin
                    state_d = WBUF_IDLE;
                    rdata_d = arb_rdata_i;
                    ack_d   = 1'b1;
                end
            end
            default: state_d = WBUF_IDLE;
        endcase
    end

    // State, ack pulse, read latch and returned load data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= WBUF_IDLE;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            rd_addr_q <= '0;
            rd_size_q <= '0;
            rd_mask_q <= '0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            rd_addr_q <= rd_addr_d;
            rd_size_q <= rd_size_d;
            rd_mask_q <= rd_mask_d;
        end
    end

`ifdef UNCACHE_WBUF_PERF_EN
    logic [31:0] stall_q, wr_q;

    // Saturating counters: CPU store cycles blocked by a full buffer, and drained stores
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            wr_q    <= '0;
        end else begin
            if (cpu_we_i && full && stall_q != '1) stall_q <= stall_q + 32'd1;
            if (pop && wr_q != '1) wr_q <= wr_q + 32'd1;
        end
    end

    assign perf_stall_o = stall_q;
    assign perf_wr_o    = wr_q;
`endif

    a_we_re_excl: assert property (@(posedge clk) disable iff (!rst) !(cpu_we_i && cpu_re_i));
    a_no_idle_refresh: assert property (@(posedge clk) disable iff (!rst) !(arb_refresh_i && state_q == WBUF_IDLE));

endmodule

// File: tb/tb_uncache_wbuf.sv
// tb_uncache_wbuf: scoreboard bench for uncache_wbuf with an arbiter model and directed stimulus
module tb_uncache_wbuf;
    logic        clk = 1'b0, rst = 1'b0;
    logic        cpu_re_i = 1'b0, cpu_we_i = 1'b0;
    logic [7:0]  cpu_mask_i = '0;
    logic [31:0] cpu_addr_i = '0;
    logic [1:0]  cpu_size_i = '0;
    logic [63:0] cpu_wdata_i = '0;
    logic [63:0] cpu_rdata_o;
    logic        cpu_refresh_o, arb_re_o, arb_we_o;
    logic [7:0]  arb_mask_o;
    logic [31:0] arb_addr_o;
    logic [1:0]  arb_size_o;
    logic [63:0] arb_wdata_o;
    logic [63:0] arb_rdata_i = '0;
    logic        arb_refresh_i = 1'b0;
`ifdef UNCACHE_WBUF_PERF_EN
    logic [31:0] perf_stall_o, perf_wr_o;
`endif

    uncache_wbuf dut (
        .clk(clk), .rst(rst),
        .cpu_re_i(cpu_re_i), .cpu_we_i(cpu_we_i), .cpu_mask_i(cpu_mask_i),
        .cpu_addr_i(cpu_addr_i), .cpu_size_i(cpu_size_i), .cpu_wdata_i(cpu_wdata_i),
        .cpu_rdata_o(cpu_rdata_o), .cpu_refresh_o(cpu_refresh_o),
        .arb_re_o(arb_re_o), .arb_we_o(arb_we_o), .arb_mask_o(arb_mask_o),
        .arb_addr_o(arb_addr_o), .arb_size_o(arb_size_o), .arb_wdata_o(arb_wdata_o),
        .arb_rdata_i(arb_rdata_i), .arb_refresh_i(arb_refresh_i)
`ifdef UNCACHE_WBUF_PERF_EN
        , .perf_stall_o(perf_stall_o), .perf_wr_o(perf_wr_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;
    int wr_done = 0, wr_pushed = 0, wr_ref_cyc = -1, rd_ref_cyc = -1, lat = 2;
    bit hold = 0, manual = 0;
    logic [63:0]  rd_val = '0;
    logic [105:0] exp_wr[$];
    logic [31:0]  exp_rd[$];
    logic [64:0]  exp_ack[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", n, got, exp);
        end
    endtask

    // Arbiter model: completes the presented request after lat cycles unless held
    initial begin
        int w = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!manual) begin
                arb_refresh_i = 1'b0;
                if (!rst) w = 0;
                else if ((arb_we_o || arb_re_o) && !hold) begin
                    if (w >= lat) begin
                        arb_refresh_i = 1'b1;
                        arb_rdata_i   = rd_val;
                        w = 0;
                    end else w++;
                end else w = 0;
            end
        end
    end

    // Monitor: pops expected traffic whenever the DUT presents a request or an ack
    initial begin
        logic pw = 0, pr = 0;
        logic [64:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (arb_we_o && !pw) begin
                    if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
                    else chk("wr_fields", {arb_addr_o, arb_size_o, arb_mask_o, arb_wdata_o}, exp_wr.pop_front());
                end
                if (arb_re_o && !pr) begin
                    if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
                    else chk("rd_addr", arb_addr_o, exp_rd.pop_front());
                    chk("rd_after_stores", wr_done, wr_pushed);
                end
                if (arb_refresh_i && arb_we_o) begin
                    wr_done++;
                    wr_ref_cyc = cyc;
                end
                if (arb_refresh_i && arb_re_o) rd_ref_cyc = cyc;
                if (cpu_refresh_o) begin
                    if (exp_ack.size() == 0) chk("ack_unexpected", 1, 0);
                    else begin
                        e = exp_ack.pop_front();
                        if (e[64]) begin
                            chk("load_data", cpu_rdata_o, e[63:0]);
                            chk("load_latency", cyc, rd_ref_cyc + 1);
                        end
                    end
                end
            end
            pw = arb_we_o;
            pr = arb_re_o;
        end
    end

    task automatic wait_ack(output int c);
        c = -1;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            #1;
            if (cpu_refresh_o) begin
                c = cyc;
                return;
            end
        end
        chk("ack_timeout", 1, 0);
    endtask

    task automatic store_set(input logic [31:0] a, input logic [63:0] d, input logic [7:0] m, input logic [1:0] s);
        exp_wr.push_back({a, s, m, d});
        exp_ack.push_back({1'b0, 64'h0});
        cpu_addr_i = a; cpu_wdata_i = d; cpu_mask_i = m; cpu_size_i = s;
        cpu_we_i = 1'b1;
    endtask

    task automatic store(input logic [31:0] a, input logic [63:0] d, input logic [7:0] m, input logic [1:0] s, output int c);
        store_set(a, d, m, s);
        wait_ack(c);
        cpu_we_i = 1'b0;
        wr_pushed++;
    endtask

    task automatic load(input logic [31:0] a, input logic [63:0] d);
        int c;
        exp_rd.push_back(a);
        exp_ack.push_back({1'b1, d});
        rd_val = d;
        cpu_addr_i = a; cpu_mask_i = 8'hff; cpu_size_i = 2'd3;
        cpu_re_i = 1'b1;
        wait_ack(c);
        cpu_re_i = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            #1;
            if (wr_done == wr_pushed && !arb_we_o && !arb_re_o) return;
        end
        chk("drain_timeout", 1, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1;
        logic seen;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {arb_we_o, arb_re_o, cpu_refresh_o, arb_addr_o, cpu_rdata_o}, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        // single store, slow arbiter
        lat = 5;
        c0 = cyc;
        store(32'ha0000000, 64'h41, 8'h01, 2'd0, c1);
        chk("t1_ack_latency", c1, c0 + 1);
        @(posedge clk);
        #1;
        chk("t1_arb_we", {arb_we_o, arb_addr_o, arb_wdata_o, arb_mask_o}, {1'b1, 32'ha0000000, 64'h41, 8'h01});
        drain();
        chk("t1_count", dut.u_fifo.count_q, 0);
        // five stores against a stalled arbiter
        hold = 1;
        for (int i = 0; i < 4; i++) store(32'h20000000 + 32'(i * 8), 64'h100 + 64'(i), 8'hff, 2'd3, c1);
        chk("t2_full", dut.u_fifo.count_q, 4);
        store_set(32'h20000020, 64'h104, 8'hff, 2'd3);
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            seen |= cpu_refresh_o;
        end
        chk("t2_stall", seen, 0);
        lat = 1;
        hold = 0;
        wait_ack(c1);
        cpu_we_i = 1'b0;
        wr_pushed++;
        chk("t2_accept_after_pop", c1, wr_ref_cyc + 2);
        drain();
`ifdef UNCACHE_WBUF_PERF_EN
        chk("perf_wr", perf_wr_o, 6);
        chk("perf_stall_nonzero", perf_stall_o != 0, 1);
`endif
        // load behind a buffered store to the same address
        lat = 5;
        store(32'h10000000, 64'h5555, 8'hff, 2'd3, c1);
        load(32'h10000000, 64'hdeadbeef);
        @(posedge clk);
        #1;
        chk("t3_rdata_hold", cpu_rdata_o, 64'hdeadbeef);
        // reset while draining with three entries
        hold = 1;
        for (int i = 0; i < 3; i++) store(32'h40000000 + 32'(i * 8), 64'h200 + 64'(i), 8'h0f, 2'd2, c1);
        @(posedge clk);
        #1;
        chk("t4_in_wr", arb_we_o, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t4_reset_ctl", {arb_we_o, arb_re_o, cpu_refresh_o, arb_addr_o, arb_mask_o}, 0);
        chk("t4_reset_data", {arb_wdata_o, cpu_rdata_o}, 0);
        exp_wr.delete();
        wr_done = wr_pushed;
        hold = 0;
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            seen |= arb_we_o;
        end
        chk("t4_no_drain", seen, 0);
        chk("t4_empty", dut.u_fifo.count_q, 0);
        // push and pop in the same cycle at count 2
        hold = 1;
        lat = 2;
        store(32'h50000000, 64'hA, 8'hff, 2'd3, c1);
        store(32'h50000008, 64'hB, 8'hff, 2'd3, c1);
        @(posedge clk);
        #1;
        manual = 1;
        chk("t5_count_before", dut.u_fifo.count_q, 2);
        store_set(32'h50000010, 64'hC, 8'hff, 2'd3);
        arb_refresh_i = 1'b1;
        @(posedge clk);
        #1;
        arb_refresh_i = 1'b0;
        chk("t5_count_same", dut.u_fifo.count_q, 2);
        chk("t5_ack", cpu_refresh_o, 1);
        cpu_we_i = 1'b0;
        wr_pushed++;
        manual = 0;
        hold = 0;
        drain();
        for (int i = 0; i < 16; i++) store(32'h30000000 + 32'(i * 8), 64'(i), 8'hff, 2'd3, c1);
        drain();
        chk("t5_count_end", dut.u_fifo.count_q, 0);
        repeat (3) @(posedge clk);
        chk("queues_empty", exp_wr.size() + exp_rd.size() + exp_ack.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
